// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared constants for the BRAM-backed FIFO controller.
package bram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 2 ** DEF_ADDR_W;
  localparam int unsigned SKID_DEPTH = 2;
  localparam int unsigned RD_LAT     = 1;

endpackage

// File: rtl/bram_fifo_ctrl_if.sv
// Stream-in, stream-out and BRAM-port bundle of the FIFO controller.
interface bram_fifo_ctrl_if
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              bram_wr_en;
  logic [ADDR_W-1:0] bram_wr_addr;
  logic [DATA_W-1:0] bram_wr_data;
  logic              bram_rd_en;
  logic [ADDR_W-1:0] bram_rd_addr;
  logic [DATA_W-1:0] bram_rd_data;

  // Controller side.
  modport slave (
    input  s_valid, s_data, m_ready, bram_rd_data,
    output s_ready, m_valid, m_data,
    output bram_wr_en, bram_wr_addr, bram_wr_data, bram_rd_en, bram_rd_addr
  );

  // Producer, consumer and BRAM side.
  modport master (
    output s_valid, s_data, m_ready, bram_rd_data,
    input  s_ready, m_valid, m_data,
    input  bram_wr_en, bram_wr_addr, bram_wr_data, bram_rd_en, bram_rd_addr
  );

endinterface

// File: rtl/bram_fifo_ctrl_rd_skid.sv
// Two-entry first-word-fall-through register buffer catching BRAM read returns.
module bram_rd_skid
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        cnt,
  output logic              valid,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;

  assign cnt   = cnt_q;
  assign valid = (cnt_q != 2'd0);
  assign head  = ent0_q;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_data;
        else               ent1_d = push_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 2'd0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO sequencer for an external 256x32 simple-dual-port BRAM with FWFT output.
// Optional BRAM_FIFO_STATUS_EN adds fill_lvl and ovf_sticky status outputs.
module bram_fifo_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  bram_fifo_ctrl_if.slave   bus
`ifdef BRAM_FIFO_STATUS_EN
  ,
  output logic [ADDR_W+1:0] fill_lvl,
  output logic              ovf_sticky
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]   bram_cnt_q, bram_cnt_d;
  logic              rd_pend_q;
  logic [1:0]        skid_cnt;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_head;
  logic              wr_acc, rd_iss, pop;

  assign bus.s_ready = !rst && (bram_cnt_q != CNT_FULL);
  assign wr_acc      = bus.s_valid && bus.s_ready;
  assign bus.m_valid = !rst && skid_valid;
  assign bus.m_data  = skid_head;
  assign pop         = bus.m_valid && bus.m_ready;

  // Issue only if the return still fits: skid_cnt + rd_pend + 1 - pop <= 2.
  assign rd_iss = !rst && (bram_cnt_q != '0) &&
                  (({1'b0, skid_cnt} + {2'b00, rd_pend_q}) <= (3'd1 + {2'b00, pop}));

  assign bus.bram_wr_en   = wr_acc;
  assign bus.bram_wr_addr = wptr_q;
  assign bus.bram_wr_data = bus.s_data;
  assign bus.bram_rd_en   = rd_iss;
  assign bus.bram_rd_addr = rptr_q;

  always_comb begin
    wptr_d     = wr_acc ? wptr_q + ADDR_W'(1) : wptr_q;
    rptr_d     = rd_iss ? rptr_q + ADDR_W'(1) : rptr_q;
    bram_cnt_d = bram_cnt_q;
    if (wr_acc && !rd_iss)      bram_cnt_d = bram_cnt_q + CNT_ONE;
    else if (!wr_acc && rd_iss) bram_cnt_d = bram_cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      bram_cnt_q <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      bram_cnt_q <= bram_cnt_d;
      rd_pend_q  <= rd_iss;
    end
  end

  // Reset clears the skid, so a read returning during reset is dropped.
  bram_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (rd_pend_q),
    .push_data (bus.bram_rd_data),
    .pop       (pop),
    .cnt       (skid_cnt),
    .valid     (skid_valid),
    .head      (skid_head)
  );

`ifdef BRAM_FIFO_STATUS_EN
  logic [ADDR_W+1:0] fill_lvl_q, fill_lvl_d;
  logic [1:0]        skid_cnt_d;
  logic              ovf_q;

  always_comb begin
    skid_cnt_d = skid_cnt + {1'b0, rd_pend_q} - {1'b0, pop};
    fill_lvl_d = {1'b0, bram_cnt_d} + {{ADDR_W{1'b0}}, skid_cnt_d} +
                 {{(ADDR_W + 1){1'b0}}, rd_iss};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_lvl_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      fill_lvl_q <= fill_lvl_d;
      if (bus.s_valid && !bus.s_ready) ovf_q <= 1'b1;
    end
  end

  assign fill_lvl   = fill_lvl_q;
  assign ovf_sticky = ovf_q;
`endif

endmodule
